// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one left-shift datapath among N_REQ requesters,
// with a single registered result slot behind a valid/ready handshake.
module shift_arbiter #(
    parameter  int unsigned WIDTH = 32,
    parameter  int unsigned N_REQ = 4,
    localparam int unsigned ID_W  = $clog2(N_REQ)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [N_REQ-1:0]       req_valid_i,
    output logic [N_REQ-1:0]       req_ready_o,
    input  logic [N_REQ*WIDTH-1:0] req_bus_i,
    input  logic [N_REQ*WIDTH-1:0] req_shift_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [WIDTH-1:0]       rsp_data_o,
    output logic [ID_W-1:0]        rsp_id_o
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic [ID_W-1:0]   id_q, id_d;

    logic              grant_vld;
    logic [ID_W-1:0]   grant_id;
    logic              slot_free;
    logic              transfer;
    logic [WIDTH-1:0]  bus_sel;
    logic [WIDTH-1:0]  shift_sel;

    // First valid index at or after rr_ptr, searching upward with wrap-around.
    always_comb begin
        int unsigned idx;
        grant_vld = 1'b0;
        grant_id  = '0;
        idx       = 0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = (32'(rr_ptr_q) + i) % N_REQ;
            if (!grant_vld && req_valid_i[idx]) begin
                grant_vld = 1'b1;
                grant_id  = ID_W'(idx);
            end
        end
    end

    assign slot_free = (state_q == EMPTY) || rsp_ready_i;
    assign transfer  = grant_vld && slot_free && !rst_i;
    assign bus_sel   = req_bus_i[grant_id*WIDTH +: WIDTH];
    assign shift_sel = req_shift_i[grant_id*WIDTH +: WIDTH];

    always_comb begin
        req_ready_o = '0;
        if (transfer) begin
            req_ready_o[grant_id] = 1'b1;
        end
    end

    always_comb begin
        int unsigned nxt;
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        data_d   = data_q;
        id_d     = id_q;
        nxt      = 32'(grant_id) + 1;
        if (transfer) begin
            state_d  = FULL;
            // Shift amounts >= WIDTH already shift every bit out, giving 0.
            data_d   = bus_sel << shift_sel;
            id_d     = grant_id;
            rr_ptr_d = (nxt == N_REQ) ? '0 : ID_W'(nxt);
        end else if (state_q == FULL && rsp_ready_i) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= EMPTY;
            rr_ptr_q <= '0;
            data_q   <= '0;
            id_q     <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            data_q   <= data_d;
            id_q     <= id_d;
        end
    end

    assign rsp_valid_o = (state_q == FULL);
    assign rsp_data_o  = data_q;
    assign rsp_id_o    = id_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed self-checking bench for shift_arbiter (WIDTH=32, N_REQ=4).
module tb_shift_arbiter;

    logic         clk;
    logic         rst;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [127:0] req_bus;
    logic [127:0] req_shift;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [31:0]  rsp_data;
    logic [1:0]   rsp_id;

    int checks;
    int failures;

    shift_arbiter #(.WIDTH(32), .N_REQ(4)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_bus_i   (req_bus),
        .req_shift_i (req_shift),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_data_o  (rsp_data),
        .rsp_id_o    (rsp_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int k, input logic [31:0] b, input logic [31:0] s);
        req_bus[k*32 +: 32]   = b;
        req_shift[k*32 +: 32] = s;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        cyc();
        for (int c = 0; c < 3; c++) begin
            #1;
            checks += 4;
            if (rsp_valid !== 1'b0) begin
                failures++;
                $display("FAIL reset_valid cyc=%0d got=%b exp=0", c, rsp_valid);
            end
            if (rsp_data !== 32'h0) begin
                failures++;
                $display("FAIL reset_data cyc=%0d got=%h exp=0", c, rsp_data);
            end
            if (rsp_id !== 2'd0) begin
                failures++;
                $display("FAIL reset_id cyc=%0d got=%0d exp=0", c, rsp_id);
            end
            if (req_ready !== 4'b0000) begin
                failures++;
                $display("FAIL reset_ready cyc=%0d got=%b exp=0000", c, req_ready);
            end
            cyc();
        end
        rst = 1'b0;
        req_valid = 4'b0000;
    endtask

    task automatic test_single();
        set_lane(2, 32'h0000_0003, 32'd4);
        req_valid = 4'b0100;
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            failures++;
            $display("FAIL single_ready got=%b exp=0100", req_ready);
        end
        cyc();
        req_valid = 4'b0000;
        checks += 3;
        if (rsp_valid !== 1'b1) begin
            failures++;
            $display("FAIL single_valid got=%b exp=1", rsp_valid);
        end
        if (rsp_data !== 32'h0000_0030) begin
            failures++;
            $display("FAIL single_data got=%h exp=00000030", rsp_data);
        end
        if (rsp_id !== 2'd2) begin
            failures++;
            $display("FAIL single_id got=%0d exp=2", rsp_id);
        end
        #1;
        checks++;
        if (req_ready !== 4'b0000) begin
            failures++;
            $display("FAIL idle_ready got=%b exp=0000", req_ready);
        end
        cyc();
        checks += 2;
        if (rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL drain_valid got=%b exp=0", rsp_valid);
        end
        if (rsp_data !== 32'h0000_0030) begin
            failures++;
            $display("FAIL drain_data_hold got=%h exp=00000030", rsp_data);
        end
    endtask

    task automatic test_saturation();
        logic [31:0] shifts [4];
        logic [31:0] exps   [4];
        shifts = '{32'd31, 32'd32, 32'd1, 32'hFFFF_FFFF};
        exps   = '{32'h8000_0000, 32'h0, 32'hFFFF_FFFE, 32'h0};
        rsp_ready = 1'b1;
        req_valid = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            set_lane(0, 32'hFFFF_FFFF, shifts[i]);
            #1;
            checks++;
            if (req_ready !== 4'b0001) begin
                failures++;
                $display("FAIL sat_ready i=%0d got=%b exp=0001", i, req_ready);
            end
            cyc();
            checks += 2;
            if (rsp_data !== exps[i]) begin
                failures++;
                $display("FAIL sat_data shift=%h got=%h exp=%h", shifts[i], rsp_data, exps[i]);
            end
            if (rsp_id !== 2'd0) begin
                failures++;
                $display("FAIL sat_id i=%0d got=%0d exp=0", i, rsp_id);
            end
        end
        req_valid = 4'b0000;
        cyc();
    endtask

    task automatic test_round_robin();
        logic [31:0] exps [4];
        exps = '{32'd1, 32'd4, 32'd12, 32'd32};
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) set_lane(k, 32'(k + 1), 32'(k));
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            checks++;
            if (req_ready !== (4'b0001 << (i % 4))) begin
                failures++;
                $display("FAIL rr_ready i=%0d got=%b exp=%b", i, req_ready, 4'b0001 << (i % 4));
            end
            cyc();
            checks += 3;
            if (rsp_valid !== 1'b1) begin
                failures++;
                $display("FAIL rr_valid i=%0d got=%b exp=1", i, rsp_valid);
            end
            if (rsp_id !== 2'(i % 4)) begin
                failures++;
                $display("FAIL rr_id i=%0d got=%0d exp=%0d", i, rsp_id, i % 4);
            end
            if (rsp_data !== exps[i % 4]) begin
                failures++;
                $display("FAIL rr_data i=%0d got=%h exp=%h", i, rsp_data, exps[i % 4]);
            end
        end
    endtask

    task automatic test_backpressure();
        // rr_ptr is 0 here; only requester 1 valid places id 1 in the slot.
        req_valid = 4'b0010;
        rsp_ready = 1'b1;
        cyc();
        rsp_ready = 1'b0;
        req_valid = 4'b1111;
        checks += 2;
        if (rsp_id !== 2'd1) begin
            failures++;
            $display("FAIL bp_load_id got=%0d exp=1", rsp_id);
        end
        if (rsp_data !== 32'd4) begin
            failures++;
            $display("FAIL bp_load_data got=%h exp=00000004", rsp_data);
        end
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if (req_ready !== 4'b0000) begin
                failures++;
                $display("FAIL bp_ready cyc=%0d got=%b exp=0000", c, req_ready);
            end
            cyc();
            checks += 3;
            if (rsp_valid !== 1'b1) begin
                failures++;
                $display("FAIL bp_valid cyc=%0d got=%b exp=1", c, rsp_valid);
            end
            if (rsp_id !== 2'd1) begin
                failures++;
                $display("FAIL bp_id cyc=%0d got=%0d exp=1", c, rsp_id);
            end
            if (rsp_data !== 32'd4) begin
                failures++;
                $display("FAIL bp_data cyc=%0d got=%h exp=00000004", c, rsp_data);
            end
        end
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            failures++;
            $display("FAIL bp_release_ready got=%b exp=0100", req_ready);
        end
        cyc();
        checks += 2;
        if (rsp_id !== 2'd2) begin
            failures++;
            $display("FAIL bp_release_id got=%0d exp=2", rsp_id);
        end
        if (rsp_data !== 32'd12) begin
            failures++;
            $display("FAIL bp_release_data got=%h exp=0000000c", rsp_data);
        end
    endtask

    task automatic test_reset_midstream();
        rst = 1'b1;
        req_valid = 4'b1111;
        #1;
        checks++;
        if (req_ready !== 4'b0000) begin
            failures++;
            $display("FAIL mid_rst_ready got=%b exp=0000", req_ready);
        end
        cyc();
        checks += 2;
        if (rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_rst_valid got=%b exp=0", rsp_valid);
        end
        if (rsp_data !== 32'h0) begin
            failures++;
            $display("FAIL mid_rst_data got=%h exp=0", rsp_data);
        end
        rst = 1'b0;
        req_valid = 4'b1010;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            failures++;
            $display("FAIL mid_first_ready got=%b exp=0010", req_ready);
        end
        cyc();
        checks++;
        if (rsp_id !== 2'd1) begin
            failures++;
            $display("FAIL mid_first_id got=%0d exp=1", rsp_id);
        end
        // Idle cycle must leave rr_ptr at 2.
        req_valid = 4'b0000;
        cyc();
        req_valid = 4'b1111;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            failures++;
            $display("FAIL hold_ptr_ready got=%b exp=0100", req_ready);
        end
        cyc();
        req_valid = 4'b1001;
        #1;
        checks++;
        if (req_ready !== 4'b1000) begin
            failures++;
            $display("FAIL ptr3_ready got=%b exp=1000", req_ready);
        end
        cyc();
        checks++;
        if (rsp_id !== 2'd3) begin
            failures++;
            $display("FAIL ptr3_id got=%0d exp=3", rsp_id);
        end
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL wrap_ready got=%b exp=0001", req_ready);
        end
        cyc();
        checks++;
        if (rsp_id !== 2'd0) begin
            failures++;
            $display("FAIL wrap_id got=%0d exp=0", rsp_id);
        end
        req_valid = 4'b0000;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        req_valid = 4'b0000;
        req_bus   = '0;
        req_shift = '0;
        rsp_ready = 1'b0;
        test_reset();
        test_single();
        test_saturation();
        test_round_robin();
        test_backpressure();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
- Shares one left-shift datapath (bus << shift, full-width shift operand) among N_REQ requesters.
- Round-robin arbitration with a valid/ready handshake per requester.
- One registered result slot with a valid/ready output handshake.
- Sits between the ALU-side issue logic and the shift datapath. The shift itself is done internally as a plain left shift of the selected operands.

Parameters:
- WIDTH, 32, data and shift-amount width in bits.
- N_REQ, 4, number of requesters; legal range 2..16.
- ID_W, $clog2(N_REQ), width of the requester id; derived, not overridden.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  synchronous active-high reset.
- req_valid_i  input  N_REQ  per-requester request valid.
- req_ready_o  output  N_REQ  per-requester accept strobe; one-hot or zero.
- req_bus_i  input  N_REQ*WIDTH  operand per requester; requester k uses bits [k*WIDTH +: WIDTH].
- req_shift_i  input  N_REQ*WIDTH  shift amount per requester, same packing as req_bus_i.
- rsp_valid_o  output  1  result slot holds a valid result.
- rsp_ready_i  input  1  consumer accepts result.
- rsp_data_o  output  WIDTH  shifted result.
- rsp_id_o  output  ID_W  index of the requester that produced rsp_data_o.

Behaviour:
- Clocking and reset:
  - One clock domain. Reset is synchronous and active-high.
  - While rst_i is high at a rising edge: state=EMPTY, rsp_valid_o=0, rsp_data_o=0, rsp_id_o=0, rr_ptr=0.
  - req_ready_o is 0 throughout reset.
- State machine, two states:
  - EMPTY: slot free.
  - FULL: slot holds an unconsumed result.
- slot_free = (state==EMPTY) | (state==FULL & rsp_ready_i).
- Arbitration (combinational):
  - Among asserted req_valid_i bits, grant the first index at or after rr_ptr, searching upward with wrap-around.
  - req_ready_o[g] = slot_free & req_valid_i[g] & granted; all other bits are 0.
  - req_ready_o may depend combinationally on req_valid_i. Requesters must not wait on req_ready_o before asserting valid.
- Handshake rules:
  - A transfer occurs when req_valid_i[k] & req_ready_o[k].
  - A requester holds valid, bus and shift stable until its transfer occurs.
- Datapath:
  - On a transfer from requester g, the next edge loads rsp_data_o = req_bus_i[g] << req_shift_i[g], truncated to WIDTH bits.
  - Any shift amount >= WIDTH yields 0.
  - The same edge loads rsp_id_o = g and sets state=FULL.
  - Latency: exactly 1 cycle from accept to rsp_valid_o.
- Pointer update: on a transfer, rr_ptr <= (g+1) mod N_REQ. With no transfer, rr_ptr holds.
- Transitions:
  - EMPTY & transfer -> FULL.
  - EMPTY & no request -> EMPTY.
  - FULL & rsp_ready_i & transfer -> FULL, with the new result loaded (back-to-back, one result per cycle).
  - FULL & rsp_ready_i & no transfer -> EMPTY; rsp_valid_o=0 and data holds its last value.
  - FULL & !rsp_ready_i -> FULL; rsp_data_o and rsp_id_o held stable, all req_ready_o=0.
- Output contract:
  - rsp_valid_o = (state==FULL).
  - rsp_data_o and rsp_id_o change only on the edge following a transfer, or on reset.
- Boundary conditions:
  - No valid requests: no grant, pointer unchanged.
  - Single persistent requester: served every cycle while rsp_ready_i is high.
  - rr_ptr at N_REQ-1 wraps to 0.
  - Reset asserted while FULL or mid-handshake drops the pending result. No grant is issued in that cycle.
  - The first grant after reset starts at index 0.

Test Plan:
- Reset → rsp_valid_o=0, rsp_data_o=0, rsp_id_o=0, req_ready_o=0 for 3 cycles with all req_valid_i=1.
- Req 2 only: bus=0x0000_0003, shift=4, rsp_ready_i=1 → req_ready_o=4'b0100 in cycle 0; cycle 1: rsp_valid_o=1, rsp_data_o=0x0000_0030, rsp_id_o=2.
- Shift saturation: bus=0xFFFF_FFFF with shift=31 → 0x8000_0000; shift=32 → 0; shift=0xFFFF_FFFF → 0.
- Round-robin: all 4 valid continuously, rsp_ready_i=1 → rsp_id_o sequence 0,1,2,3,0,… one per cycle, no bubbles.
- Backpressure: slot FULL with id=1, rsp_ready_i=0 for 5 cycles → rsp_data_o/rsp_id_o stable and req_ready_o=0. Then rsp_ready_i=1 → same-cycle accept of the next requester (id 2 if valid).
- Reset mid-stream: rst_i=1 while FULL → next cycle rsp_valid_o=0. After release with reqs 1 and 3 valid, requester 1 is granted first (rr_ptr=0).
